// File: rtl/case_1_mul_pipe.sv
// case_1_mul_pipe: pipelined multiplier with valid/ready, optional saturation via CASE_1_MUL_PIPE_SAT_EN
module case_1_mul_pipe #(
   parameter int ID          = 1,
   parameter int NUM_STAGE   = 2,
   parameter int din0_WIDTH  = 14,
   parameter int din1_WIDTH  = 12,
   parameter int dout_WIDTH  = 26,
   parameter bit din0_SIGNED = 0,
   parameter bit din1_SIGNED = 1
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [dout_WIDTH-1:0] dout,
   output logic [2:0]            occupancy
);
   localparam int MW = din0_WIDTH + din1_WIDTH + 2;
`ifdef CASE_1_MUL_PIPE_SAT_EN
   localparam bit RS = din0_SIGNED || din1_SIGNED;
   localparam logic signed [MW-1:0] ONE  = MW'(1);
   localparam logic signed [MW-1:0] SMAX = (ONE <<< (dout_WIDTH - 1)) - ONE;
   localparam logic signed [MW-1:0] SMIN = -(ONE <<< (dout_WIDTH - 1));
   localparam logic signed [MW-1:0] UMAX = (ONE <<< dout_WIDTH) - ONE;
`endif
   logic signed [MW-1:0] a_ext, b_ext, prod;
   logic [dout_WIDTH-1:0] res;
   logic [NUM_STAGE-1:0] vld_q, vld_d;
   logic [NUM_STAGE-1:0][dout_WIDTH-1:0] data_q, data_d;
   logic [2:0] occ_q, occ_d;
   logic advance, accept, emit;
   // operand extension, multiply and output wrap or clamp ahead of stage 0
   always_comb begin
      a_ext = $signed({{(MW - din0_WIDTH){din0_SIGNED & din0[din0_WIDTH-1]}}, din0});
      b_ext = $signed({{(MW - din1_WIDTH){din1_SIGNED & din1[din1_WIDTH-1]}}, din1});
      prod  = a_ext * b_ext;
`ifdef CASE_1_MUL_PIPE_SAT_EN
      res = RS ? (prod > SMAX ? SMAX[dout_WIDTH-1:0] : prod < SMIN ? SMIN[dout_WIDTH-1:0] : dout_WIDTH'(prod))
               : (prod > UMAX ? UMAX[dout_WIDTH-1:0] : dout_WIDTH'(prod));
`else
      res = dout_WIDTH'(prod);
`endif
   end
   // global-stall shift of all stages and occupancy bookkeeping
   always_comb begin
      advance = !vld_q[NUM_STAGE-1] || out_ready;
      accept  = in_valid && advance;
      emit    = vld_q[NUM_STAGE-1] && out_ready;
      vld_d   = vld_q;
      data_d  = data_q;
      if (advance) begin
         vld_d[0]  = accept;
         data_d[0] = res;
         for (int i = 1; i < NUM_STAGE; i++) begin
            vld_d[i]  = vld_q[i-1];
            data_d[i] = data_q[i-1];
         end
      end
      occ_d = occ_q + {2'b0, accept} - {2'b0, emit};
   end
   // stage registers with synchronous active-low clear
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         vld_q  <= '0;
         data_q <= '0;
         occ_q  <= '0;
      end else begin
         vld_q  <= vld_d;
         data_q <= data_d;
         occ_q  <= occ_d;
      end
   end
   assign in_ready  = advance;
   assign out_valid = vld_q[NUM_STAGE-1];
   assign dout      = out_valid ? data_q[NUM_STAGE-1] : '0;
   assign occupancy = occ_q;
endmodule
